// File: rtl/tl_slave_port_arbiter.sv
// tl_slave_port_arbiter
// Shares the tile's TileLink-UL slave port between two external requesters (r0, r1).
// The A channel is arbitrated round-robin with a zero-latency combinational path. The
// requester index is prepended to the A source so D responses can be routed back by source MSB.
// Per-requester outstanding counters bound how many A requests each side may have in flight.
//
// Ports
//   clock, reset                   clock and synchronous active-high reset
//   r{0,1}_a_valid/ready/bits      requester A channels (117-bit bits, 4-bit source)
//   r{0,1}_d_valid/ready/bits      requester D channels (79-bit bits, 4-bit source)
//   t_a_valid/ready/bits           tile A channel (118-bit bits, 5-bit source)
//   t_d_valid/ready/bits           tile D channel (80-bit bits, 5-bit source)
//   busy                           registered: any outstanding count nonzero
//   err_unexp_d                    one-cycle pulse: D response for a requester with count 0
module tl_slave_port_arbiter #(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned SRC_W     = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                r0_a_valid,
  output logic                r0_a_ready,
  input  logic [113+SRC_W-1:0] r0_a_bits,
  output logic                r0_d_valid,
  input  logic                r0_d_ready,
  output logic [75+SRC_W-1:0] r0_d_bits,
  input  logic                r1_a_valid,
  output logic                r1_a_ready,
  input  logic [113+SRC_W-1:0] r1_a_bits,
  output logic                r1_d_valid,
  input  logic                r1_d_ready,
  output logic [75+SRC_W-1:0] r1_d_bits,
  output logic                t_a_valid,
  input  logic                t_a_ready,
  output logic [114+SRC_W-1:0] t_a_bits,
  input  logic                t_d_valid,
  output logic                t_d_ready,
  input  logic [76+SRC_W-1:0] t_d_bits,
  output logic                busy,
  output logic                err_unexp_d
);

  localparam int unsigned AW        = 113 + SRC_W;
  localparam int unsigned TDW       = 76 + SRC_W;
  // Bit position of the source field LSB within A bits and D bits respectively.
  localparam int unsigned A_SRC_LSB = 104;
  localparam int unsigned D_SRC_LSB = 67;
  localparam logic [3:0]  MAX_CNT   = 4'(MAX_OUTST);

  logic       r_out_en;
  logic       r_rr_ptr;
  logic       r_lock;
  logic       r_lock_idx;
  logic [3:0] r_cnt0;
  logic [3:0] r_cnt1;
  logic       r_busy;
  logic       r_err;

  logic          w_en;
  logic          w_room0;
  logic          w_room1;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_g;
  logic          w_t_a_valid;
  logic [AW-1:0] w_ga_bits;
  logic          w_a_fire;
  logic          w_a_fire0;
  logic          w_a_fire1;
  logic          w_sel;
  logic          w_d_fire;
  logic          w_d_fire0;
  logic          w_d_fire1;
  logic          w_lock_req_valid;
  logic [3:0]    w_cnt0_d;
  logic [3:0]    w_cnt1_d;
  logic          w_err_d;

  // Handshake outputs stay low during reset and for the first cycle after it.
  assign w_en = r_out_en & ~reset;

  assign w_room0 = (r_cnt0 < MAX_CNT);
  assign w_room1 = (r_cnt1 < MAX_CNT);
  assign w_elig0 = r0_a_valid & w_room0;
  assign w_elig1 = r1_a_valid & w_room1;

  always_comb begin
    w_g = r_rr_ptr;
    if (r_lock) begin
      w_g = r_lock_idx;
    end else if (w_elig0 && w_elig1) begin
      w_g = r_rr_ptr;
    end else if (w_elig1) begin
      w_g = 1'b1;
    end else if (w_elig0) begin
      w_g = 1'b0;
    end
  end

  assign w_t_a_valid = w_en & (w_g ? w_elig1 : w_elig0);
  assign w_ga_bits   = w_g ? r1_a_bits : r0_a_bits;

  assign t_a_valid = w_t_a_valid;
  assign t_a_bits  = {w_ga_bits[AW-1:A_SRC_LSB+SRC_W], w_g, w_ga_bits[A_SRC_LSB+SRC_W-1:0]};

  // A requester at its outstanding limit never sees ready, even if it holds the grant.
  assign r0_a_ready = w_en & ~w_g & w_room0 & t_a_ready;
  assign r1_a_ready = w_en &  w_g & w_room1 & t_a_ready;

  assign w_a_fire  = w_t_a_valid & t_a_ready;
  assign w_a_fire0 = w_a_fire & ~w_g;
  assign w_a_fire1 = w_a_fire &  w_g;

  // D path: source MSB names the requester the response belongs to.
  assign w_sel      = t_d_bits[D_SRC_LSB+SRC_W];
  assign r0_d_valid = w_en & t_d_valid & ~w_sel;
  assign r1_d_valid = w_en & t_d_valid &  w_sel;
  assign t_d_ready  = w_en & (w_sel ? r1_d_ready : r0_d_ready);
  assign r0_d_bits  = {t_d_bits[TDW-1:D_SRC_LSB+SRC_W+1], t_d_bits[D_SRC_LSB+SRC_W-1:0]};
  assign r1_d_bits  = {t_d_bits[TDW-1:D_SRC_LSB+SRC_W+1], t_d_bits[D_SRC_LSB+SRC_W-1:0]};

  assign w_d_fire  = w_en & t_d_valid & t_d_ready;
  assign w_d_fire0 = w_d_fire & ~w_sel;
  assign w_d_fire1 = w_d_fire &  w_sel;

  assign w_lock_req_valid = r_lock_idx ? r1_a_valid : r0_a_valid;

  // Simultaneous A and D fire for one requester cancel out; decrement saturates at zero.
  always_comb begin
    w_cnt0_d = r_cnt0;
    if (w_a_fire0 && !w_d_fire0) begin
      if (r_cnt0 < MAX_CNT) w_cnt0_d = r_cnt0 + 4'd1;
    end else if (w_d_fire0 && !w_a_fire0) begin
      if (r_cnt0 != 4'd0) w_cnt0_d = r_cnt0 - 4'd1;
    end
  end

  always_comb begin
    w_cnt1_d = r_cnt1;
    if (w_a_fire1 && !w_d_fire1) begin
      if (r_cnt1 < MAX_CNT) w_cnt1_d = r_cnt1 + 4'd1;
    end else if (w_d_fire1 && !w_a_fire1) begin
      if (r_cnt1 != 4'd0) w_cnt1_d = r_cnt1 - 4'd1;
    end
  end

  assign w_err_d = (w_d_fire0 && (r_cnt0 == 4'd0)) || (w_d_fire1 && (r_cnt1 == 4'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_en   <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_idx <= 1'b0;
      r_cnt0     <= 4'd0;
      r_cnt1     <= 4'd0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      r_cnt0   <= w_cnt0_d;
      r_cnt1   <= w_cnt1_d;
      r_busy   <= (w_cnt0_d != 4'd0) || (w_cnt1_d != 4'd0);
      r_err    <= w_err_d;
      if (w_a_fire) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= ~w_g;
      end else if (w_t_a_valid) begin
        // Stalled: pin the grant so t_a_bits stay stable until the tile accepts.
        r_lock     <= 1'b1;
        r_lock_idx <= w_g;
      end else if (r_lock && !w_lock_req_valid) begin
        // Locked requester withdrew its request; release the grant.
        r_lock <= 1'b0;
      end
    end
  end

  assign busy        = r_busy;
  assign err_unexp_d = r_err;

endmodule
